// File: rtl/tt_um_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tt_um_serial_subtractor
//   Bit-serial subtractor, D = A - B (mod 2^OP_BITS), one bit per clock,
//   LSB first. Operands are loaded from ui_in. A start/busy/done handshake
//   returns the result on uo_out.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst_n    : synchronous active-low reset
//   ui_in    : operand data byte
//   uio_in   : [0] load_a, [1] load_b, [2] start, [7:3] ignored
//   uo_out   : result register D (upper bits 0 when OP_BITS < 8)
//   uio_out  : [7] busy, [6] done, [5] borrow_out, [4] zero, [3:0] = 0
//   uio_oe   : constant 8'hF0 (upper nibble of uio is output)
//   ena      : ignored
// -----------------------------------------------------------------------------
module tt_um_serial_subtractor #(
  parameter int OP_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(OP_BITS - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [OP_BITS-1:0]   r_a;
  logic [OP_BITS-1:0]   r_b;
  logic [OP_BITS-1:0]   r_shift;
  logic [OP_BITS-1:0]   r_d;
  logic [2:0]           r_cnt;
  logic                 r_brw;
  logic                 r_borrow_out;
  logic                 r_zero;

  logic                 w_load_a;
  logic                 w_load_b;
  logic                 w_start;
  logic                 w_last;
  logic                 w_a_bit;
  logic                 w_b_bit;
  logic                 w_d_bit;
  logic                 w_brw_next;
  logic [OP_BITS-1:0]   w_shift_next;
  logic                 w_unused;

  assign w_load_a = uio_in[0];
  assign w_load_b = uio_in[1];
  assign w_start  = uio_in[2];
  assign w_unused = &{1'b0, ena, uio_in[7:3]};

  // Operands are indexed rather than shifted so a repeated start recomputes
  // the same result without reloading.
  assign w_last     = (r_cnt == LAST_BIT);
  assign w_a_bit    = r_a[r_cnt];
  assign w_b_bit    = r_b[r_cnt];
  assign w_d_bit    = w_a_bit ^ w_b_bit ^ r_brw;
  assign w_brw_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_brw);

  // New bit enters at the MSB; after OP_BITS shifts bit 0 holds d_0.
  assign w_shift_next = (r_shift >> 1) | (OP_BITS'(w_d_bit) << (OP_BITS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start wins over loads, DONE lasts exactly one cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (w_start) w_state_next = S_RUN;
        else         w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, serial borrow chain, result commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_shift      <= '0;
      r_d          <= '0;
      r_cnt        <= '0;
      r_brw        <= 1'b0;
      r_borrow_out <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_cnt <= '0;
            r_brw <= 1'b0;
          end else begin
            if (w_load_a) r_a <= ui_in[OP_BITS-1:0];
            if (w_load_b) r_b <= ui_in[OP_BITS-1:0];
          end
        end
        S_RUN: begin
          r_shift <= w_shift_next;
          r_brw   <= w_brw_next;
          r_cnt   <= r_cnt + 3'd1;
          // Visible result and flags change only on completion
          if (w_last) begin
            r_d          <= w_shift_next;
            r_borrow_out <= w_brw_next;
            r_zero       <= (w_shift_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign uo_out  = 8'(r_d);
  assign uio_out = {(r_state == S_RUN), (r_state == S_DONE), r_borrow_out, r_zero, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_tt_um_serial_subtractor
//   Directed bench for the bit-serial subtractor tile: reset, normal and
//   borrow subtraction, edge operands, ignored inputs, mid-run reset and a
//   batch of random operand pairs.
// -----------------------------------------------------------------------------
module tb_tt_um_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  int n_pass;
  int n_total;

  tt_um_serial_subtractor #(.OP_BITS(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    ui_in = a; uio_in = 8'h01; step();
    ui_in = b; uio_in = 8'h02; step();
    uio_in = 8'h00; ui_in = 8'h00;
  endtask

  task automatic start_run();
    uio_in = 8'h04; step();
    uio_in = 8'h00;
  endtask

  // Called just after the start edge plus 'already' RUN edges. Checks busy on
  // each remaining cycle, then the one-cycle done and the committed result.
  task automatic finish_run(input string tag, input int already, input logic [7:0] exp_d,
                            input logic exp_brw, input logic exp_zero);
    for (int i = already; i < 8; i++) begin
      check({tag, "_busy"}, {14'd0, uio_out[7:6]}, 16'h0002);
      step();
    end
    check({tag, "_done"}, {14'd0, uio_out[7:6]}, 16'h0001);
    check({tag, "_d"}, {8'd0, uo_out}, {8'd0, exp_d});
    check({tag, "_flags"}, {14'd0, uio_out[5:4]}, {14'd0, exp_brw, exp_zero});
  endtask

  task automatic after_done_idle(input string tag);
    step();
    check({tag, "_pulse"}, {14'd0, uio_out[7:6]}, 16'h0000);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rdiff;
    n_pass  = 0;
    n_total = 0;
    ena     = 1'b1;
    rst_n   = 1'b0;
    ui_in   = 8'h00;
    uio_in  = 8'h00;

    // 1. Reset with random inputs
    ui_in = 8'($urandom); uio_in = 8'($urandom); step();
    ui_in = 8'($urandom); uio_in = 8'($urandom); step();
    check("rst_uo_out", {8'd0, uo_out}, 16'h0000);
    check("rst_uio_out", {8'd0, uio_out}, 16'h0000);
    check("rst_uio_oe", {8'd0, uio_oe}, 16'h00F0);
    rst_n = 1'b1; ui_in = 8'h00; uio_in = 8'h00; step();
    check("idle_status", {8'd0, uio_out}, 16'h0000);

    // 2. No-borrow subtraction
    load_ops(8'h5A, 8'h23);
    check("hold_before_run", {8'd0, uo_out}, 16'h0000);
    start_run();
    finish_run("sub_5a_23", 0, 8'h37, 1'b0, 1'b0);
    after_done_idle("sub_5a_23");

    // 3. Borrow case and restart without reload
    load_ops(8'h10, 8'h20);
    start_run();
    // Previous result must hold during RUN
    check("hold_during_run", {8'd0, uo_out}, 16'h0037);
    finish_run("sub_10_20", 0, 8'hF0, 1'b1, 1'b0);
    after_done_idle("sub_10_20");
    start_run();
    finish_run("restart_10_20", 0, 8'hF0, 1'b1, 1'b0);
    after_done_idle("restart_10_20");

    // 4. Edge operands
    load_ops(8'h81, 8'h81);
    start_run();
    finish_run("eq_81", 0, 8'h00, 1'b0, 1'b1);
    after_done_idle("eq_81");
    load_ops(8'h00, 8'hFF);
    start_run();
    finish_run("sub_00_ff", 0, 8'h01, 1'b1, 1'b0);
    after_done_idle("sub_00_ff");
    load_ops(8'hFF, 8'h00);
    start_run();
    finish_run("sub_ff_00", 0, 8'hFF, 1'b0, 1'b0);
    after_done_idle("sub_ff_00");

    // 5a. load_a and start during RUN are ignored
    load_ops(8'h5A, 8'h23);
    start_run();
    step();
    ui_in = 8'h99; uio_in = 8'h05; step();
    uio_in = 8'h00; ui_in = 8'h00;
    finish_run("run_ignore", 2, 8'h37, 1'b0, 1'b0);
    after_done_idle("run_ignore");

    // 5b. start with load_a in IDLE: start taken, A kept
    ui_in = 8'h99; uio_in = 8'h05; step();
    uio_in = 8'h00; ui_in = 8'h00;
    finish_run("start_pri", 0, 8'h37, 1'b0, 1'b0);

    // 5c. start in the DONE cycle begins a new run
    load_ops(8'h10, 8'h20);
    start_run();
    finish_run("pre_done_start", 0, 8'hF0, 1'b1, 1'b0);
    start_run();
    finish_run("done_start", 0, 8'hF0, 1'b1, 1'b0);
    after_done_idle("done_start");

    // 6a. Reset in RUN cycle 4 aborts without a done pulse
    load_ops(8'h5A, 8'h23);
    start_run();
    step(); step(); step();
    check("midrun_busy", {14'd0, uio_out[7:6]}, 16'h0002);
    rst_n = 1'b0; step();
    check("midrun_rst_uo", {8'd0, uo_out}, 16'h0000);
    check("midrun_rst_uio", {8'd0, uio_out}, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("no_done_after_abort", {8'd0, uio_out}, 16'h0000);
    end

    // 6b. Random operand pairs
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rdiff = ra - rb;
      load_ops(ra, rb);
      start_run();
      finish_run("rand", 0, rdiff, (ra < rb), (rdiff == 8'h00));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tt_um_serial_subtractor.md
Name: tt_um_serial_subtractor

Overview:
- Bit-serial 8-bit subtractor that computes D = A - B, LSB first, one bit per clock.
- Companion to the team's combinational prefix adder tile: it performs the inverse operation sequentially. Operands are loaded over the shared ui_in bus, and the result is returned on uo_out with a start/busy/done handshake.
- Sits directly in the TinyTapeout user-tile wrapper.

Parameters:
- OP_BITS, 8, operand/result width and number of RUN cycles; must be 8 at the tile top; 1..8 allowed in unit benches, with unused upper uo_out bits driven 0.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset; synchronous, active-low
- ui_in  input  8  operand data byte
- uio_in  input  8  control: [0] load_a, [1] load_b, [2] start; [7:3] ignored
- uo_out  output  8  result register D (A - B mod 2^OP_BITS)
- uio_out  output  8  status: [7] busy, [6] done, [5] borrow_out, [4] zero; [3:0] = 0
- uio_oe  output  8  constant 8'hF0
- ena  input  1  ignored

Behaviour:
- Reset: rst_n low at a rising edge forces the following on that same edge:
  - A, B, D, borrow, bit counter = 0; state = IDLE.
  - uo_out = 0x00, busy = 0, done = 0, borrow_out = 0, zero = 0.
  - Reset mid-RUN aborts the operation; done is never raised for the aborted run.
- States: IDLE, RUN, DONE.
- IDLE / DONE:
  - start=1 → RUN. Clear counter and borrow (borrow-in = 0). busy=1 and done=0 from the next cycle.
  - start has priority: load_a/load_b in the same cycle are ignored.
  - Else load_a=1 captures ui_in into A; load_b=1 captures ui_in into B. Both set captures the same byte into both.
  - DONE with no start → IDLE after exactly one cycle. done is a 1-cycle pulse.
- RUN, bit i = counter:
  - d_i = A[i] ^ B[i] ^ brw.
  - brw' = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & brw).
  - d_i is written into an internal shift register; counter increments.
  - A and B are indexed, not shifted, so operands are preserved and a repeated start recomputes the same result.
  - load_a, load_b and start are ignored in RUN.
  - After processing bit OP_BITS-1 → DONE. On that same edge:
    - D is updated from the shift register;
    - borrow_out = final brw (1 iff A < B unsigned);
    - zero = (result == 0);
    - busy = 0, done = 1.
- Timing: start sampled at edge k → busy high after edges k .. k+7; done high after edge k+8. Latency is 8 cycles start→result.
- uo_out, borrow_out and zero hold their last values until the next completion or reset. They do not change during RUN.
- No combinational paths from inputs to outputs; all outputs are registered.
- Implementation: three-state FSM, 3-bit counter, single borrow flop, A/B/shift/D registers.

Test Plan:
1. Reset:
   - Stimulus: hold rst_n low 2 cycles with random ui_in/uio_in.
   - Required: uo_out=0x00, uio_out=0x00, uio_oe=0xF0; release gives IDLE with busy=0.
2. No-borrow subtraction:
   - Stimulus: load_a 0x5A, load_b 0x23, start at edge k.
   - Required: busy=1 for exactly 8 cycles; done=1 for one cycle after edge k+8; uo_out=0x37, borrow_out=0, zero=0.
3. Borrow case and restart:
   - Stimulus: A=0x10, B=0x20.
   - Required: uo_out=0xF0, borrow_out=1. A second start with no reload gives the identical result after 8 cycles.
4. Edge cases:
   - A=B=0x81 → uo_out=0x00, zero=1, borrow_out=0.
   - A=0x00, B=0xFF → uo_out=0x01, borrow_out=1.
   - A=0xFF, B=0x00 → 0xFF, borrow_out=0.
5. Ignored inputs:
   - load_a=0x99 and start pulsed during RUN → ignored; result reflects the original operands.
   - start+load_a in the same IDLE cycle → start accepted, A unchanged.
   - start in the DONE cycle → new RUN accepted.
6. Reset mid-run and random check:
   - rst_n low at RUN cycle 4 → next edge all outputs 0, no done pulse.
   - Then 256 random A/B pairs: uo_out == (A-B) mod 256 and borrow_out == (A<B) on every done.
